// File: rtl/alu_issue_stage_if.sv
// Handshake bundle between decode, the ALU issue stage and EX.
//   Decode -> stage : in_valid, rs1_data, rs2_data, imm, rs1, rs2, rd, alu_op, funct3,
//                     funct7b5, alu_src, is_rtype
//   Stage -> decode : in_ready
//   Stage -> EX     : out_valid, SrcA, SrcB, Operation, store_data, rd_q, illegal_op
//   EX -> stage     : out_ready
// The slave modport is the issue stage's view; master is the surrounding pipeline.
interface alu_issue_stage_if #(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned OPCODE_LENGTH = 4,
    parameter int unsigned REG_ADDR_W    = 5
) ();
    logic                     in_valid;
    logic                     in_ready;
    logic [DATA_WIDTH-1:0]    rs1_data;
    logic [DATA_WIDTH-1:0]    rs2_data;
    logic [DATA_WIDTH-1:0]    imm;
    logic [REG_ADDR_W-1:0]    rs1;
    logic [REG_ADDR_W-1:0]    rs2;
    logic [REG_ADDR_W-1:0]    rd;
    logic [1:0]               alu_op;
    logic [2:0]               funct3;
    logic                     funct7b5;
    logic                     alu_src;
    logic                     is_rtype;

    logic                     out_valid;
    logic                     out_ready;
    logic [DATA_WIDTH-1:0]    SrcA;
    logic [DATA_WIDTH-1:0]    SrcB;
    logic [OPCODE_LENGTH-1:0] Operation;
    logic [DATA_WIDTH-1:0]    store_data;
    logic [REG_ADDR_W-1:0]    rd_q;
    logic                     illegal_op;

    modport master (
        output in_valid, rs1_data, rs2_data, imm, rs1, rs2, rd, alu_op, funct3, funct7b5,
               alu_src, is_rtype, out_ready,
        input  in_ready, out_valid, SrcA, SrcB, Operation, store_data, rd_q, illegal_op
    );

    modport slave (
        input  in_valid, rs1_data, rs2_data, imm, rs1, rs2, rd, alu_op, funct3, funct7b5,
               alu_src, is_rtype, out_ready,
        output in_ready, out_valid, SrcA, SrcB, Operation, store_data, rd_q, illegal_op
    );
endinterface

// File: rtl/alu_issue_stage.sv
// ID/EX register stage feeding the ALU. Holds one decoded instruction under a
// valid/ready handshake, decodes ALUOp/funct3/funct7 into the ALU Operation code
// at capture, and presents SrcA/SrcB/store_data from the held operands.
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   flush             drop the held instruction and any same-cycle input beat
//   bus (slave)       decode input channel and EX output channel
//   mem_wr_en/rd/result, wb_wr_en/rd/result   forwarding sources (EX/MEM, MEM/WB)
// Build option: define ALU_ISSUE_FWD_EN to include the forwarding muxes; otherwise
// operands come straight from the held register-file data and mem_*/wb_* are ignored.
module alu_issue_stage #(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned OPCODE_LENGTH = 4,
    parameter int unsigned REG_ADDR_W    = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    alu_issue_stage_if.slave      bus,
    input  logic                  mem_wr_en,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic [DATA_WIDTH-1:0] mem_result,
    input  logic                  wb_wr_en,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic [DATA_WIDTH-1:0] wb_result
);
    localparam logic [OPCODE_LENGTH-1:0] OpAnd = OPCODE_LENGTH'(4'b0000);
    localparam logic [OPCODE_LENGTH-1:0] OpOr  = OPCODE_LENGTH'(4'b0001);
    localparam logic [OPCODE_LENGTH-1:0] OpAdd = OPCODE_LENGTH'(4'b0010);
    localparam logic [OPCODE_LENGTH-1:0] OpSub = OPCODE_LENGTH'(4'b0110);
    localparam logic [OPCODE_LENGTH-1:0] OpEq  = OPCODE_LENGTH'(4'b1000);
    localparam logic [OPCODE_LENGTH-1:0] OpBad = OPCODE_LENGTH'(4'b1111);

    logic                     valid_q;
    logic [DATA_WIDTH-1:0]    rs1_data_q;
    logic [DATA_WIDTH-1:0]    rs2_data_q;
    logic [DATA_WIDTH-1:0]    imm_q;
    logic [REG_ADDR_W-1:0]    rs1_q;
    logic [REG_ADDR_W-1:0]    rs2_q;
    logic [REG_ADDR_W-1:0]    rd_q;
    logic                     alu_src_q;
    logic [OPCODE_LENGTH-1:0] op_q;
    logic                     illegal_q;

    logic                     in_ready;
    logic                     capture;
    logic [OPCODE_LENGTH-1:0] op_d;
    logic                     illegal_d;
    logic [DATA_WIDTH-1:0]    fwd_a;
    logic [DATA_WIDTH-1:0]    fwd_b;

    assign in_ready = !valid_q || bus.out_ready;
    assign capture  = bus.in_valid && in_ready;

    always_comb begin
        op_d      = OpBad;
        illegal_d = 1'b1;
        unique case (bus.alu_op)
            2'b00: begin op_d = OpAdd; illegal_d = 1'b0; end
            2'b01: begin op_d = OpEq;  illegal_d = 1'b0; end
            2'b10: begin
                unique case (bus.funct3)
                    3'b000: begin
                        // funct7b5 only selects SUB for R-type; I-type ADDI reuses bit 30
                        op_d      = (bus.is_rtype && bus.funct7b5) ? OpSub : OpAdd;
                        illegal_d = 1'b0;
                    end
                    3'b111:  begin op_d = OpAnd; illegal_d = 1'b0; end
                    3'b110:  begin op_d = OpOr;  illegal_d = 1'b0; end
                    default: begin op_d = OpBad; illegal_d = 1'b1; end
                endcase
            end
            default: begin op_d = OpBad; illegal_d = 1'b1; end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q    <= 1'b0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            imm_q      <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rd_q       <= '0;
            alu_src_q  <= 1'b0;
            op_q       <= '0;
            illegal_q  <= 1'b0;
        end else if (flush) begin
            // Flush wins over a same-cycle capture; held fields are left as-is.
            valid_q <= 1'b0;
        end else if (capture) begin
            valid_q    <= 1'b1;
            rs1_data_q <= bus.rs1_data;
            rs2_data_q <= bus.rs2_data;
            imm_q      <= bus.imm;
            rs1_q      <= bus.rs1;
            rs2_q      <= bus.rs2;
            rd_q       <= bus.rd;
            alu_src_q  <= bus.alu_src;
            op_q       <= op_d;
            illegal_q  <= illegal_d;
        end else if (bus.out_ready) begin
            valid_q <= 1'b0;
        end
    end

`ifdef ALU_ISSUE_FWD_EN
    // Younger result (EX/MEM) takes precedence; x0 is hardwired and never forwarded.
    always_comb begin
        fwd_a = rs1_data_q;
        if (rs1_q != '0 && mem_wr_en && mem_rd == rs1_q) begin
            fwd_a = mem_result;
        end else if (rs1_q != '0 && wb_wr_en && wb_rd == rs1_q) begin
            fwd_a = wb_result;
        end
        fwd_b = rs2_data_q;
        if (rs2_q != '0 && mem_wr_en && mem_rd == rs2_q) begin
            fwd_b = mem_result;
        end else if (rs2_q != '0 && wb_wr_en && wb_rd == rs2_q) begin
            fwd_b = wb_result;
        end
    end
`else
    logic unused_fwd;
    assign unused_fwd = ^{mem_wr_en, mem_rd, mem_result, wb_wr_en, wb_rd, wb_result,
                          rs1_q, rs2_q};
    assign fwd_a = rs1_data_q;
    assign fwd_b = rs2_data_q;
`endif

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = valid_q;
    assign bus.SrcA       = fwd_a;
    assign bus.SrcB       = alu_src_q ? imm_q : fwd_b;
    assign bus.store_data = fwd_b;
    assign bus.Operation  = op_q;
    assign bus.rd_q       = rd_q;
    assign bus.illegal_op = illegal_q;
endmodule
